dbus_mmio: RTL
==============

Name: dbus_mmio

Overview:
- Data-side bus block directly downstream of the single-cycle CPU core.
- Consumes the core's memory address (ALU result), store data and MemWrite, and returns readdata in the same cycle.
- Decodes a word-addressed data RAM plus a small MMIO region: LED output register, switch input, a programmable down-counting timer with an interrupt flag, and a free-running cycle counter.
- Gives test programs real memory and observable I/O.

Parameters:
- DMEM_WORDS, 128, data RAM depth in 32-bit words; power of two, at most 1024.
- MMIO_BASE, 32'h0000_7F00, base byte address of the MMIO window; above the RAM range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- MemWrite  input  1  store strobe from the core.
- addr  input  32  byte address (core ALU result); bits [1:0] ignored.
- writedata  input  32  store data from the core.
- readdata  output  32  load data to the core; combinational.
- sw  input  16  board switches.
- led  output  16  LED register.
- timer_irq  output  1  timer interrupt request, level.

Behaviour:
- Reset (rst=1 at an edge):
  - led=0, timer ctrl=0, load=0, count=0, irq flag=0, cycle counter=0.
  - Timer state goes to IDLE.
  - RAM contents are not reset; they are preserved across reset.
- Address map (word aligned):
  - RAM: addr < DMEM_WORDS*4, indexed by addr[log2(DMEM_WORDS)+1:2].
  - MMIO_BASE+0x00 LED (RW).
  - +0x04 SW (RO; zero-extended).
  - +0x10 TCTRL (RW): bit0 EN, bit1 AUTO, bit2 FLAG (reads flag; writing 1 clears), bit3 IRQEN.
  - +0x14 TLOAD (RW).
  - +0x18 TCOUNT (RO).
  - +0x1C CYCLE (RO).
- Unmapped addresses: read 0; writes ignored. Writes to RO registers are ignored.
- Reads are combinational from current state. A read in the same cycle as a write to the same location returns the old value.
- Writes take effect at the edge where MemWrite=1.
- Cycle counter: increments every cycle; wraps from 0xFFFF_FFFF to 0.
- Timer FSM:
  - IDLE: a write setting EN=1 loads count<=TLOAD (the value stored before this write) and moves to RUN.
  - RUN:
    - EN written 0: go to IDLE; count holds.
    - Otherwise, if count != 0: count<=count-1.
    - If count == 0: set FLAG. Then, if AUTO=1, count<=TLOAD and stay in RUN; otherwise clear EN and go to EXPIRED.
  - EXPIRED: count holds at 0. A write with EN=1 reloads count and returns to RUN. A write with EN=0 goes to IDLE.
- Timer timing and corner cases:
  - With load value L written before enable, FLAG rises after the (L+1)th edge following the enabling write edge.
  - L=0 sets FLAG one edge after enable.
  - Writing EN=1 while already in RUN does not restart the count. AUTO and IRQEN update immediately.
  - Writing TLOAD during RUN affects only the next reload.
  - FLAG clear and FLAG set in the same cycle: set wins.
- timer_irq = FLAG & IRQEN; registered-state derived, no combinational path from inputs.
- Reset asserted mid-count: timer goes to IDLE, count=0, FLAG=0 at that edge.

Optional Feature:
- Macro: DBUS_BYTE_STORE_EN.
- When defined:
  - Adds port mem_be input [3:0], byte write enables for sb/sh.
  - RAM writes update only the bytes whose enable is set.
  - MMIO writes require mem_be==4'hF; otherwise the write is ignored.
- When undefined: every store is a full-word write; the port is absent.

Decomposition:
- Package dbus_pkg:
  - MMIO offset constants (LED, SW, TCTRL, TLOAD, TCOUNT, CYCLE).
  - TCTRL bit index constants.
  - Timer state encoding (IDLE, RUN, EXPIRED).
- Sub-module dbus_timer: owns the timer FSM, count, load, ctrl and flag. Interface: write strobes per register, write data, read values, irq.
- The top level holds the RAM, address decode, LED register, cycle counter and readdata mux.

Test Plan:
- RAM round trip: write 0xDEADBEEF to addr 0x40, then read 0x40 → 0xDEADBEEF; read 0x42 → same value (low address bits ignored).
- LED and switches: write 0x1234_A5A5 to LED → led=0xA5A5; sw=0x00F0, read SW → 0x0000_00F0.
- Reset: assert rst for 1 cycle → led=0, CYCLE reads 0; previously written RAM word at 0x40 still reads 0xDEADBEEF.
- One-shot timer:
  - Setup: TLOAD=5, then TCTRL=0x9 (EN, IRQEN).
  - timer_irq must rise exactly 6 edges after the enabling edge.
  - After expiry: TCTRL reads EN=0, FLAG=1; TCOUNT=0.
  - Write TCTRL=0x4 → irq deasserts next cycle.
- Auto-reload with collision:
  - Setup: TLOAD=2, TCTRL=0xB (EN, AUTO, IRQEN).
  - FLAG must set every 3 cycles.
  - A W1C write landing on a set cycle must leave FLAG=1.
- Unmapped and RO writes: write to MMIO_BASE+0x08 and to CYCLE → no state change; a read of +0x08 returns 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared constants for the dbus_mmio data-bus block: MMIO word offsets,
// TCTRL bit positions and the timer state encoding.
package dbus_pkg;

  // MMIO register offsets in words from MMIO_BASE (byte offset / 4)
  localparam logic [2:0] WOFF_LED    = 3'd0;  // +0x00
  localparam logic [2:0] WOFF_SW     = 3'd1;  // +0x04
  localparam logic [2:0] WOFF_TCTRL  = 3'd4;  // +0x10
  localparam logic [2:0] WOFF_TLOAD  = 3'd5;  // +0x14
  localparam logic [2:0] WOFF_TCOUNT = 3'd6;  // +0x18
  localparam logic [2:0] WOFF_CYCLE  = 3'd7;  // +0x1C

  localparam int TCTRL_EN    = 0;
  localparam int TCTRL_AUTO  = 1;
  localparam int TCTRL_FLAG  = 2;
  localparam int TCTRL_IRQEN = 3;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_EXPIRED = 2'd2
  } timer_state_e;

  function automatic logic [31:0] tctrl_word(input logic en, input logic auto_rl,
                                             input logic flag, input logic irqen);
    return {28'h0, irqen, flag, auto_rl, en};
  endfunction

endpackage

// File: rtl/dbus_mmio_if.sv
// Core-to-data-bus interface. Stores commit at the rising edge while MemWrite=1;
// readdata is combinational from addr. mem_be exists only with DBUS_BYTE_STORE_EN.
interface dbus_mmio_if;
  import dbus_pkg::*;

  logic         MemWrite;
  logic [31:0]  addr;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
`ifdef DBUS_BYTE_STORE_EN
  logic [3:0]   mem_be;
`endif
  timer_state_e dbg_timer_state;

`ifdef DBUS_BYTE_STORE_EN
  modport master (output MemWrite, addr, writedata, mem_be,
                  input  readdata, dbg_timer_state);
  modport slave  (input  MemWrite, addr, writedata, mem_be,
                  output readdata, dbg_timer_state);
`else
  modport master (output MemWrite, addr, writedata,
                  input  readdata, dbg_timer_state);
  modport slave  (input  MemWrite, addr, writedata,
                  output readdata, dbg_timer_state);
`endif

endinterface

// File: rtl/dbus_timer.sv
// Programmable down-counting timer with sticky FLAG, optional auto-reload
// and level interrupt (FLAG & IRQEN).
module dbus_timer
  import dbus_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_tctrl_i,
  input  logic         we_tload_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  tctrl_o,
  output logic [31:0]  tload_o,
  output logic [31:0]  tcount_o,
  output logic         irq_o,
  output timer_state_e state_o
);

  timer_state_e state_q, state_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  load_q, load_d;
  logic         auto_q, auto_d;
  logic         irqen_q, irqen_d;
  logic         flag_q, flag_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= T_IDLE;
      count_q <= '0;
      load_q  <= '0;
      auto_q  <= 1'b0;
      irqen_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      auto_q  <= auto_d;
      irqen_q <= irqen_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_d  = load_q;
    auto_d  = auto_q;
    irqen_d = irqen_q;
    flag_d  = flag_q;

    if (we_tload_i) load_d = wdata_i;
    if (we_tctrl_i) begin
      auto_d  = wdata_i[TCTRL_AUTO];
      irqen_d = wdata_i[TCTRL_IRQEN];
      if (wdata_i[TCTRL_FLAG]) flag_d = 1'b0;
    end

    // Reloads use load_q so a TLOAD write never races the value it replaces.
    // The FLAG set below comes after the W1C above, so set wins a collision.
    unique case (state_q)
      T_IDLE: begin
        if (we_tctrl_i && wdata_i[TCTRL_EN]) begin
          count_d = load_q;
          state_d = T_RUN;
        end
      end
      T_RUN: begin
        if (we_tctrl_i && !wdata_i[TCTRL_EN]) begin
          state_d = T_IDLE;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          flag_d = 1'b1;
          if (auto_d) count_d = load_q;
          else        state_d = T_EXPIRED;
        end
      end
      T_EXPIRED: begin
        if (we_tctrl_i) begin
          if (wdata_i[TCTRL_EN]) begin
            count_d = load_q;
            state_d = T_RUN;
          end else begin
            state_d = T_IDLE;
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign tctrl_o  = tctrl_word(state_q == T_RUN, auto_q, flag_q, irqen_q);
  assign tload_o  = load_q;
  assign tcount_o = count_q;
  assign irq_o    = flag_q & irqen_q;
  assign state_o  = state_q;

endmodule

// File: rtl/dbus_mmio.sv
// Data-side bus: word RAM, LED/switch registers, timer and cycle counter behind
// an MMIO window. Define DBUS_BYTE_STORE_EN for byte-enabled RAM stores.
module dbus_mmio
  import dbus_pkg::*;
#(
  parameter int          DMEM_WORDS = 128,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  dbus_mmio_if.slave  bus,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  logic [31:0]      mem_q [DMEM_WORDS];
  logic [15:0]      led_q, led_d;
  logic [31:0]      cycle_q, cycle_d;

  logic             ram_sel;
  logic [IDX_W-1:0] ram_idx;
  logic             in_mmio;
  logic [29:0]      mmio_woff;
  logic             mmio_we;
  logic [31:0]      rdata;

  logic [31:0]      tctrl_rd, tload_rd, tcount_rd;
  timer_state_e     timer_state;

  assign ram_sel   = bus.addr < 32'(DMEM_WORDS * 4);
  assign ram_idx   = bus.addr[IDX_W+1:2];
  assign mmio_woff = bus.addr[31:2] - MMIO_BASE[31:2];
  assign in_mmio   = !ram_sel && (bus.addr[31:2] >= MMIO_BASE[31:2]) && (mmio_woff < 30'd8);

`ifdef DBUS_BYTE_STORE_EN
  assign mmio_we = bus.MemWrite && in_mmio && (bus.mem_be == 4'hF);
`else
  assign mmio_we = bus.MemWrite && in_mmio;
`endif

  // RAM is intentionally outside reset so program data survives a core reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && ram_sel) begin
`ifdef DBUS_BYTE_STORE_EN
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) mem_q[ram_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
`else
      mem_q[ram_idx] <= bus.writedata;
`endif
    end
  end

  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    if (mmio_we && mmio_woff[2:0] == WOFF_LED) led_d = bus.writedata[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  dbus_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_tctrl_i (mmio_we && mmio_woff[2:0] == WOFF_TCTRL),
    .we_tload_i (mmio_we && mmio_woff[2:0] == WOFF_TLOAD),
    .wdata_i    (bus.writedata),
    .tctrl_o    (tctrl_rd),
    .tload_o    (tload_rd),
    .tcount_o   (tcount_rd),
    .irq_o      (timer_irq),
    .state_o    (timer_state)
  );

  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = mem_q[ram_idx];
    end else if (in_mmio) begin
      unique case (mmio_woff[2:0])
        WOFF_LED:    rdata = {16'h0, led_q};
        WOFF_SW:     rdata = {16'h0, sw};
        WOFF_TCTRL:  rdata = tctrl_rd;
        WOFF_TLOAD:  rdata = tload_rd;
        WOFF_TCOUNT: rdata = tcount_rd;
        WOFF_CYCLE:  rdata = cycle_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.readdata        = rdata;
  assign bus.dbg_timer_state = timer_state;
  assign led                 = led_q;

endmodule
